muldiv_unit: RTL and testbench

Iterative RV32M multiply/divide unit in the execute stage of the RISC-V pipeline. Accepts one MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU operation per START and returns a 32-bit RESULT with a one-cycle VALID pulse. RESULT drives one data input of the write-back source multiplexer. The pipeline stalls while BUSY is high.

---
 rtl/muldiv_unit.sv | 156 +++++++++++++++
 tb/tb_muldiv_unit.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit.
// Multiplies take one product cycle plus a fix-up cycle. Divides run a
// restoring divider on operand magnitudes, one quotient bit per cycle,
// then apply sign correction and special-case overrides in the fix-up cycle.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            flush,
    input  logic [2:0]      func3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            busy,
    output logic            valid,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN);

    typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_t;

    state_t state, state_nxt;
    logic   accept;

    logic [2:0]      op_q;
    logic [XLEN-1:0] a_q, b_q;         // raw operands (multiply, div-by-zero remainder)
    logic [XLEN-1:0] dvsr_q;           // divisor magnitude
    logic [XLEN-1:0] quo_q;            // dividend shifts out, quotient shifts in
    logic [XLEN-1:0] rem_q;
    logic [CW-1:0]   cnt_q;
    logic [2*XLEN-1:0] prod_q;
    logic            neg_quo_q, neg_rem_q, dz_q, ovf_q;

    // Operand conditioning at latch time
    logic            sgn_div;
    logic [XLEN-1:0] a_mag, b_mag;
    assign sgn_div = ~func3[0];
    assign a_mag   = (sgn_div && op_a[XLEN-1]) ? -op_a : op_a;
    assign b_mag   = (sgn_div && op_b[XLEN-1]) ? -op_b : op_b;

    // Multiplier: operands sign/zero extended, product kept modulo 2^(2*XLEN)
    logic              a_sgn, b_sgn;
    logic [2*XLEN-1:0] a_w, b_w, prod_full;
    assign a_sgn     = (op_q != 3'b011);
    assign b_sgn     = ~op_q[1];
    assign a_w       = {{XLEN{a_sgn & a_q[XLEN-1]}}, a_q};
    assign b_w       = {{XLEN{b_sgn & b_q[XLEN-1]}}, b_q};
    assign prod_full = a_w * b_w;

    // One restoring-division step
    logic [XLEN:0]   rem_sh;
    logic            ge;
    logic [XLEN-1:0] rem_sub;
    assign rem_sh  = {rem_q, quo_q[XLEN-1]};
    assign ge      = rem_sh >= {1'b0, dvsr_q};
    assign rem_sub = rem_sh[XLEN-1:0] - dvsr_q;

    // Final result selection with sign fix-up and special-case overrides
    logic [XLEN-1:0] quo_fix, rem_fix, fix_res;
    always_comb begin
        quo_fix = neg_quo_q ? -quo_q : quo_q;
        rem_fix = neg_rem_q ? -rem_q : rem_q;
        if (dz_q) begin
            quo_fix = '1;
            rem_fix = a_q;
        end
        if (ovf_q) begin
            quo_fix = {1'b1, {(XLEN-1){1'b0}}};
            rem_fix = '0;
        end
        if (!op_q[2])
            fix_res = (op_q[1:0] == 2'b00) ? prod_q[XLEN-1:0] : prod_q[2*XLEN-1:XLEN];
        else
            fix_res = op_q[1] ? rem_fix : quo_fix;
    end

    // State register
    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state and status outputs; flush overrides everything but reset
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        valid     = 1'b0;
        accept    = (state == IDLE || state == DONE) && start && !flush;
        case (state)
            IDLE: if (accept) state_nxt = func3[2] ? DIV : MUL;
            MUL: begin
                busy      = 1'b1;
                state_nxt = FIX;
            end
            DIV: begin
                busy = 1'b1;
                if (cnt_q == CW'(XLEN-1)) state_nxt = FIX;
            end
            FIX: begin
                busy      = 1'b1;
                state_nxt = DONE;
            end
            DONE: begin
                valid     = 1'b1;
                state_nxt = accept ? (func3[2] ? DIV : MUL) : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (flush) state_nxt = IDLE;
    end

    // Datapath: operand latch, multiply, divide iterations, result register
    always_ff @(posedge clk) begin
        if (!reset) begin
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            dvsr_q    <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            cnt_q     <= '0;
            prod_q    <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_q      <= 1'b0;
            ovf_q     <= 1'b0;
            result    <= '0;
        end else if (accept) begin
            op_q      <= func3;
            a_q       <= op_a;
            b_q       <= op_b;
            dvsr_q    <= b_mag;
            quo_q     <= a_mag;
            rem_q     <= '0;
            cnt_q     <= '0;
            neg_quo_q <= sgn_div & (op_a[XLEN-1] ^ op_b[XLEN-1]);
            neg_rem_q <= sgn_div & op_a[XLEN-1];
            dz_q      <= (op_b == '0);
            ovf_q     <= sgn_div && (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);
        end else begin
            case (state)
                MUL: prod_q <= prod_full;
                DIV: begin
                    rem_q <= ge ? rem_sub : rem_sh[XLEN-1:0];
                    quo_q <= {quo_q[XLEN-2:0], ge};
                    cnt_q <= cnt_q + CW'(1);
                end
                FIX: if (!flush) result <= fix_res;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: the driver pushes expected results,
// a negedge monitor pops and checks result, latency, BUSY span and pulse width.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [2:0]  func3 = '0;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic        busy, valid;
    logic [31:0] result;

    always #5 clk = ~clk;

    muldiv_unit #(.XLEN(32)) dut (
        .clk(clk), .reset(reset), .start(start), .flush(flush), .func3(func3),
        .op_a(op_a), .op_b(op_b), .busy(busy), .valid(valid), .result(result)
    );

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] res;
        int unsigned due;
        int unsigned lat;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    int          n_chk = 0, n_pass = 0;
    logic [31:0] last_res = '0;
    int          busy_run = 0;
    bit          prev_valid = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic bound_fail(input string name);
        n_chk++;
        $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
    endtask

    // Reference model: RV32M semantics with wide integer arithmetic
    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sbv, p;
        longint unsigned up;
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        case (f)
            3'd0: begin p = sa * sbv; return p[31:0]; end
            3'd1: begin p = sa * sbv; return p[63:32]; end
            3'd2: begin p = sa * longint'({32'b0, b}); return p[63:32]; end
            3'd3: begin up = {32'b0, a} * {32'b0, b}; return up[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFFFFFF;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
                p = sa / sbv; return p[31:0];
            end
            3'd5: return (b == 0) ? 32'hFFFFFFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
                p = sa % sbv; return p[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic logic [31:0] rnd_op();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFFFFFF;
            3: return 32'h80000000;
            4: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // Monitor
    always @(negedge clk) begin
        if (reset && valid) begin
            if (sb.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_valid: VALID high with no pending op, result %h", result);
            end else begin
                e = sb.pop_front();
                chk("result", result, e.res);
                chk("latency", cyc, e.due);
                chk("busy_cycles", busy_run, e.lat);
                chk("pulse_width", {31'b0, prev_valid}, 32'h0);
                last_res = e.res;
            end
        end
        prev_valid = valid;
        busy_run   = busy ? busy_run + 1 : 0;
    end

    // Issue one op; caller sits at a negedge with BUSY low
    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input bit keep);
        int unsigned lat;
        lat   = f[2] ? 33 : 2;
        start = 1'b1; func3 = f; op_a = a; op_b = b;
        @(posedge clk); #1;
        if (keep) sb.push_back('{exp, cyc + lat, lat});
        start = 1'b0; func3 = 3'($urandom); op_a = $urandom; op_b = $urandom;
    endtask

    // Step through the busy window, optionally throwing ignored STARTs at it
    task automatic run_busy(input bit junk);
        int k = 0;
        @(negedge clk);
        while (busy && k < 100) begin
            if (junk) begin
                start = 1'($urandom_range(0, 1));
                func3 = 3'($urandom); op_a = $urandom; op_b = $urandom;
            end
            @(negedge clk);
            k++;
        end
        start = 1'b0;
        if (k >= 100) bound_fail("busy_timeout");
    endtask

    task automatic drain();
        int k = 0;
        while (sb.size() != 0 && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (k >= 100) bound_fail("drain_timeout");
    endtask

    initial begin
        logic [2:0]  f;
        logic [31:0] a, b;

        repeat (2) @(negedge clk);
        chk("reset_busy", {31'b0, busy}, 32'h0);
        chk("reset_valid", {31'b0, valid}, 32'h0);
        chk("reset_result", result, 32'h0);
        reset = 1'b1;
        @(negedge clk);

        // Directed values; each later op starts in the previous op's DONE cycle
        issue(3'd0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 1); run_busy(1);
        issue(3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 1); run_busy(0);
        issue(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1); run_busy(1);
        issue(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1); run_busy(0);
        issue(3'd4, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 1); run_busy(1);
        issue(3'd6, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 1); run_busy(0);
        issue(3'd5, 32'd5, 32'd0, 32'hFFFFFFFF, 1); run_busy(1);
        issue(3'd6, 32'd5, 32'd0, 32'd5, 1); run_busy(1);
        issue(3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1); run_busy(0);
        issue(3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h0, 1); run_busy(1);
        drain();

        // Flush at iteration 10 of a divide, then DIVU 100/7 one cycle later
        @(negedge clk);
        issue(3'd4, 32'd1000, 32'd3, 32'h0, 0);
        repeat (10) @(negedge clk);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_busy", {31'b0, busy}, 32'h0);
        chk("flush_valid", {31'b0, valid}, 32'h0);
        chk("flush_result", result, last_res);
        @(negedge clk);
        issue(3'd5, 32'd100, 32'd7, 32'd14, 1); run_busy(1);
        drain();

        // START together with FLUSH is dropped
        @(negedge clk);
        start = 1'b1; flush = 1'b1; func3 = 3'd0; op_a = 32'd3; op_b = 32'd3;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        chk("start_flush_busy", {31'b0, busy}, 32'h0);
        @(negedge clk);
        chk("start_flush_valid", {31'b0, valid}, 32'h0);
        chk("start_flush_result", result, last_res);

        // Reset at iteration 5 of a divide
        issue(3'd4, 32'd12345, 32'd7, 32'h0, 0);
        repeat (5) @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("midop_reset_busy", {31'b0, busy}, 32'h0);
        chk("midop_reset_valid", {31'b0, valid}, 32'h0);
        chk("midop_reset_result", result, 32'h0);
        last_res = '0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Randomized ops against the model, with junk STARTs while busy
        for (int i = 0; i < 80; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            f = 3'($urandom_range(0, 7));
            a = rnd_op();
            b = rnd_op();
            issue(f, a, b, model(f, a, b), 1);
            run_busy(1);
        end
        drain();
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
